// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency counter: FSM states
// and the result byte-select encoding.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] BYTE_SEL_0 = 2'd0;  // result[7:0]
  localparam logic [1:0] BYTE_SEL_1 = 2'd1;  // result[15:8]
  localparam logic [1:0] BYTE_SEL_2 = 2'd2;  // result[23:16]
  localparam logic [1:0] BYTE_SEL_3 = 2'd3;  // result[31:24]

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      BYTE_SEL_0: return word[7:0];
      BYTE_SEL_1: return word[15:8];
      BYTE_SEL_2: return word[23:16];
      default:    return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Control/status bundle of the ring-oscillator frequency counter.
// The master side drives the controls; the counter is the slave.
interface ro_freq_counter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             start;
  logic             continuous;
  logic [1:0]       byte_sel;
  logic [CNT_W-1:0] result;
  logic [7:0]       result_byte;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output enable, start, continuous, byte_sel,
    input  result, result_byte, busy, done, overflow
  );

  modport slave (
    input  enable, start, continuous, byte_sel,
    output result, result_byte, busy, done, overflow
  );
endinterface

// File: rtl/ro_sync_edge.sv
// Multi-flop synchroniser for the free-running oscillator plus a
// one-cycle rising-edge pulse in the clk domain.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign rise_pulse = sync_out & ~sync_d;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts synchronised ring-oscillator rising edges over a 2**GATE_LOG2 clk
// gate window and holds the saturated count with byte-selectable readout.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_LOG2   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               osc_in,
  ro_freq_counter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_nxt;
  logic                 edge_pulse;
  logic                 gate_last;
  logic [GATE_LOG2-1:0] gate_cnt;
  logic [CNT_W-1:0]     edge_cnt, edge_cnt_nxt;
  logic                 ovf_q, ovf_nxt;
  logic [CNT_W-1:0]     result_q;
  logic                 overflow_q;

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (osc_in),
    .sync_out   (),
    .rise_pulse (edge_pulse)
  );

  assign gate_last = &gate_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start)                      state_nxt = COUNT;
        COUNT:   if (gate_last)                      state_nxt = DONE;
        DONE:    if (bus.continuous || bus.start)    state_nxt = COUNT;
        default:                                     state_nxt = IDLE;
      endcase
    end
  end

  // Saturating edge count; the flag latches once the ceiling is reached.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    if (edge_pulse && (edge_cnt != CNT_MAX)) edge_cnt_nxt = edge_cnt + 1'b1;
    ovf_nxt = ovf_q | (edge_cnt_nxt == CNT_MAX);
  end

  // Counters run only inside the window and sit at zero otherwise, so each
  // entry into COUNT starts clean and an aborted window leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (state == COUNT) begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_cnt_nxt;
      ovf_q    <= ovf_nxt;
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_q    <= 1'b0;
    end
  end

  // Result is loaded only on a completed window, including its final edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if ((state == COUNT) && (state_nxt == DONE)) begin
      result_q   <= edge_cnt_nxt;
      overflow_q <= ovf_nxt;
    end
  end

  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state)
      COUNT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
    bus.result      = result_q;
    bus.overflow    = overflow_q;
    bus.result_byte = pick_byte(32'(result_q), bus.byte_sel);
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: a 16-bit and an 8-bit counter see the
// same oscillator and controls; expected counts come from window/period math.
module tb_ro_freq_counter;

  localparam int GATE = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       osc_in = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] byte_sel = 2'd0;

  always #5 clk = ~clk;

  ro_freq_counter_if #(.CNT_W(16)) if16 ();
  ro_freq_counter_if #(.CNT_W(8))  if8 ();

  assign if16.enable     = enable;
  assign if16.start      = start;
  assign if16.continuous = continuous;
  assign if16.byte_sel   = byte_sel;
  assign if8.enable      = enable;
  assign if8.start       = start;
  assign if8.continuous  = continuous;
  assign if8.byte_sel    = byte_sel;

  ro_freq_counter #(.CNT_W(16), .GATE_LOG2(10), .SYNC_STAGES(2)) dut16 (
    .clk (clk), .rst_n (rst_n), .osc_in (osc_in), .bus (if16.slave)
  );

  ro_freq_counter #(.CNT_W(8), .GATE_LOG2(10), .SYNC_STAGES(2)) dut8 (
    .clk (clk), .rst_n (rst_n), .osc_in (osc_in), .bus (if8.slave)
  );

  typedef struct {
    int res;
    bit ovf;
    bit wild;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t last16, last8, e16, e8;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a strictly periodic oscillator puts exactly GATE/period
  // rising edges into any GATE consecutive cycles; the count then saturates.
  function automatic exp_t model(input int period, input int cnt_w, input bit wild);
    exp_t e;
    int   edges;
    int   sat;
    edges  = (period == 0) ? 0 : GATE / period;
    sat    = (1 << cnt_w) - 1;
    e.res  = (edges > sat) ? sat : edges;
    e.ovf  = (edges >= sat);
    e.wild = wild;
    return e;
  endfunction

  function automatic logic [31:0] byte_of(input int res, input logic [1:0] sel);
    return (res >> (8 * sel)) & 32'hFF;
  endfunction

  task automatic push(input int period, input bit wild = 1'b0);
    q16.push_back(model(period, 16, wild));
    q8.push_back(model(period, 8, wild));
  endtask

  // Oscillator: period in clk cycles, 50% duty, 0 holds the line low.
  int osc_period = 0;
  int ph = 0;
  always @(negedge clk) begin
    if (osc_period == 0) begin
      ph     = 0;
      osc_in = 1'b0;
    end else begin
      ph     = (ph + 1) % osc_period;
      osc_in = (ph < osc_period / 2);
    end
  end

  // Monitors: pop and compare on each rising edge of done.
  logic done16_d = 1'b0;
  logic done8_d  = 1'b0;
  int   busy_len16 = 0;
  int   cyc = 0;
  int   last_rise = -1;
  bit   cont_mode = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (if16.done && !done16_d) begin
      check("busy_len16", busy_len16, GATE);
      if (cont_mode && last_rise >= 0) check("done_interval", cyc - last_rise, GATE + 1);
      last_rise = cont_mode ? cyc : -1;
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got result %0d, expected no measurement", if16.result);
      end else begin
        e16 = q16.pop_front();
        if (!e16.wild) begin
          check("result16", if16.result, e16.res);
          check("overflow16", if16.overflow, e16.ovf);
          check("result_byte16", if16.result_byte, byte_of(e16.res, byte_sel));
          last16 = e16;
        end
      end
    end
    busy_len16 = if16.busy ? busy_len16 + 1 : 0;
    done16_d   = if16.done;
  end

  always @(negedge clk) begin
    if (if8.done && !done8_d) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got result %0d, expected no measurement", if8.result);
      end else begin
        e8 = q8.pop_front();
        if (!e8.wild) begin
          check("result8", if8.result, e8.res);
          check("overflow8", if8.overflow, e8.ovf);
          check("result_byte8", if8.result_byte, byte_of(e8.res, byte_sel));
          last8 = e8;
        end
      end
    end
    done8_d = if8.done;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic prev;
    prev = if16.done;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if16.done && !prev) return;
      prev = if16.done;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done rise within %0d cycles, expected one", budget);
  endtask

  task automatic single_shot(input int period);
    exp_t x16, x8;
    osc_period = period;
    byte_sel   = 2'($urandom_range(0, 3));
    repeat (10) @(negedge clk);
    push(period);
    x16 = model(period, 16, 1'b0);
    x8  = model(period, 8, 1'b0);
    pulse_start();
    wait_done(GATE + 100);
    repeat (5) @(negedge clk);
    check("done_held", if16.done, 1);
    check("result_held16", if16.result, x16.res);
    for (int s = 0; s < 4; s++) begin
      byte_sel = 2'(s);
      #1;
      check("byte_sweep16", if16.result_byte, byte_of(x16.res, 2'(s)));
      check("byte_sweep8", if8.result_byte, byte_of(x8.res, 2'(s)));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    last16 = model(0, 16, 1'b0);
    last8  = model(0, 8, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_result16", if16.result, 0);
    check("reset_busy16", if16.busy, 0);
    check("reset_done16", if16.done, 0);
    check("reset_overflow16", if16.overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    enable = 1'b1;

    // Directed shots: nominal, fast limit (saturates the 8-bit unit), stopped.
    single_shot(4);
    single_shot(2);
    single_shot(0);
    for (int i = 0; i < 6; i++) single_shot(1 << $urandom_range(1, 7));

    // A start pulse mid-window must not restart the gate.
    osc_period = 4;
    repeat (10) @(negedge clk);
    push(4);
    pulse_start();
    repeat (300) @(negedge clk);
    pulse_start();
    wait_done(GATE + 100);

    // Abort at cycle 500 of a window: back to IDLE, prior result kept.
    pulse_start();
    repeat (500) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", if16.busy, 0);
    check("abort_done", if16.done, 0);
    check("abort_result16", if16.result, last16.res);
    check("abort_result8", if8.result, last8.res);
    check("abort_overflow8", if8.overflow, last8.ovf);
    repeat (1100) @(negedge clk);
    check("idle_result16", if16.result, last16.res);
    check("idle_busy", if16.busy, 0);

    // Enable and start rising together starts a measurement.
    osc_period = 8;
    repeat (10) @(negedge clk);
    push(8);
    enable = 1'b1;
    start  = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(GATE + 100);

    // Asynchronous reset in the middle of a window.
    osc_period = 4;
    pulse_start();
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy16", if16.busy, 0);
    check("rst_done16", if16.done, 0);
    check("rst_result16", if16.result, 0);
    check("rst_overflow8", if8.overflow, 0);
    check("rst_result_byte8", if8.result_byte, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_busy", if16.busy, 0);
    check("post_rst_done", if16.done, 0);

    // Continuous mode, period 8 then 16; the window spanning the change is skipped.
    osc_period = 8;
    byte_sel   = 2'd0;
    repeat (20) @(negedge clk);
    cont_mode  = 1'b1;
    continuous = 1'b1;
    push(8);
    pulse_start();
    wait_done(GATE + 100);
    push(8);
    wait_done(GATE + 100);
    osc_period = 16;
    push(16, 1'b1);
    wait_done(GATE + 100);
    push(16);
    wait_done(GATE + 100);
    push(16);
    @(negedge clk);
    continuous = 1'b0;
    cont_mode  = 1'b0;
    wait_done(GATE + 100);
    repeat (5) @(negedge clk);
    check("cont_done_held", if16.done, 1);

    check("queue16_empty", q16.size(), 0);
    check("queue8_empty", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
